// File: rtl/divider.sv
// Sequential restoring divider: 2N-bit dividend / N-bit divisor -> 2N-bit quotient
// and N-bit remainder, one quotient bit per clock, MSB first.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-low reset (0 = reset)
//   a      dividend, sampled on the accepting edge
//   b      divisor, sampled on the accepting edge
//   start  request, accepted only while idle
//   quot   quotient (registered)
//   rem    remainder (registered)
//   div0   last completed operation had a zero divisor
//   ready  result valid; held until the next accepted start
module divider #(
    parameter int unsigned N = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2*N-1:0]   a,
    input  logic [N-1:0]     b,
    input  logic             start,
    output logic [2*N-1:0]   quot,
    output logic [N-1:0]     rem,
    output logic             div0,
    output logic             ready
);

    localparam int unsigned QW   = 2 * N;
    localparam int unsigned CW   = $clog2(QW);
    localparam int unsigned LAST = QW - 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t          state;
    logic [QW-1:0]   dividend;
    logic [N-1:0]    divisor;
    // Partial remainder is always < divisor, so its N+1'th bit only exists in trial.
    logic [N-1:0]    rem_part;
    logic [QW-1:0]   quot_part;
    logic [CW-1:0]   cnt;

    logic [N:0]      trial;
    logic            fits;

    // Shift the next dividend bit into the partial remainder and compare in N+1 bits.
    always_comb begin
        trial = {rem_part, dividend[QW-1]};
        fits  = (trial >= {1'b0, divisor});
    end

    // Control FSM and datapath.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            dividend  <= '0;
            divisor   <= '0;
            rem_part  <= '0;
            quot_part <= '0;
            cnt       <= '0;
            quot      <= '0;
            rem       <= '0;
            div0      <= 1'b0;
            ready     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        dividend  <= a;
                        divisor   <= b;
                        rem_part  <= '0;
                        quot_part <= '0;
                        cnt       <= '0;
                        ready     <= 1'b0;
                        div0      <= 1'b0;
                        state     <= (b == '0) ? FINISH : RUN;
                    end
                end
                RUN: begin
                    if (fits) begin
                        rem_part <= N'(trial - {1'b0, divisor});
                    end else begin
                        rem_part <= trial[N-1:0];
                    end
                    quot_part <= {quot_part[QW-2:0], fits};
                    dividend  <= {dividend[QW-2:0], 1'b0};
                    cnt       <= cnt + CW'(1);
                    if (cnt == CW'(LAST)) begin
                        state <= FINISH;
                    end
                end
                FINISH: begin
                    if (divisor == '0) begin
                        quot <= '1;
                        rem  <= '0;
                        div0 <= 1'b1;
                    end else begin
                        quot <= quot_part;
                        rem  <= rem_part;
                        div0 <= 1'b0;
                    end
                    ready <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_divider.sv
// Self-checking bench for divider (N=4): directed table, start-ignore and
// mid-operation reset sequences, and a multiply-then-divide sweep.
module tb_divider;

    localparam int unsigned N  = 4;
    localparam int unsigned QW = 2 * N;

    logic          clk;
    logic          reset;
    logic [QW-1:0] a;
    logic [N-1:0]  b;
    logic          start;
    logic [QW-1:0] quot;
    logic [N-1:0]  rem;
    logic          div0;
    logic          ready;

    int checks   = 0;
    int failures = 0;
    logic [QW-1:0] prev_q;

    typedef struct {
        logic [QW-1:0] a;
        logic [N-1:0]  b;
        logic [QW-1:0] q;
        logic [N-1:0]  r;
        logic          d0;
    } vec_t;

    vec_t vecs[10];

    divider #(.N(N)) dut (
        .clk   (clk),
        .reset (reset),
        .a     (a),
        .b     (b),
        .start (start),
        .quot  (quot),
        .rem   (rem),
        .div0  (div0),
        .ready (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Launch one operation, optionally re-pulse start at edge E<inject_at>, check result.
    task automatic do_op(input string name, input logic [QW-1:0] av, input logic [N-1:0] bv,
                         input logic [QW-1:0] eq, input logic [N-1:0] er, input logic ed,
                         input int inject_at);
        int lat;
        int exp_lat;
        exp_lat = ed ? 1 : QW + 1;
        @(negedge clk);
        a = av;
        b = bv;
        start = 1'b1;
        @(posedge clk);
        #1;
        check({name, "_accept_ready"}, int'(ready), 0);
        check({name, "_accept_quot_hold"}, int'(quot), int'(prev_q));
        lat = 0;
        while (!ready && lat < 20) begin
            @(negedge clk);
            if (inject_at != 0 && lat + 1 == inject_at) begin
                start = 1'b1;
                a = ~av;
                b = bv + 4'd1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        start = 1'b0;
        check({name, "_latency"}, lat, exp_lat);
        check({name, "_quot"}, int'(quot), int'(eq));
        check({name, "_rem"}, int'(rem), int'(er));
        check({name, "_div0"}, int'(div0), int'(ed));
        prev_q = eq;
    endtask

    initial begin
        vecs[0] = '{8'd143, 4'd11, 8'd13,  4'd0,  1'b0};
        vecs[1] = '{8'd255, 4'd1,  8'd255, 4'd0,  1'b0};
        vecs[2] = '{8'd7,   4'd9,  8'd0,   4'd7,  1'b0};
        vecs[3] = '{8'd200, 4'd0,  8'hFF,  4'd0,  1'b1};
        vecs[4] = '{8'd100, 4'd7,  8'd14,  4'd2,  1'b0};
        vecs[5] = '{8'd200, 4'd3,  8'd66,  4'd2,  1'b0};
        vecs[6] = '{8'd254, 4'd15, 8'd16,  4'd14, 1'b0};
        vecs[7] = '{8'd0,   4'd5,  8'd0,   4'd0,  1'b0};
        vecs[8] = '{8'd255, 4'd15, 8'd17,  4'd0,  1'b0};
        vecs[9] = '{8'd15,  4'd0,  8'hFF,  4'd0,  1'b1};

        reset = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        prev_q = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ready", int'(ready), 0);
        check("reset_quot", int'(quot), 0);
        check("reset_rem", int'(rem), 0);
        check("reset_div0", int'(div0), 0);
        @(negedge clk);
        reset = 1'b1;

        // Idle with start low: outputs hold.
        repeat (2) @(posedge clk);
        #1;
        check("idle_ready", int'(ready), 0);

        for (int i = 0; i < 10; i++) begin
            do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r,
                  vecs[i].d0, 0);
        end

        // Start re-pulsed with other operands at E3 must be ignored.
        do_op("ignore_start", 8'd143, 4'd11, 8'd13, 4'd0, 1'b0, 3);
        // Idle must still be idle afterwards: nothing was queued.
        repeat (3) @(posedge clk);
        #1;
        check("no_queue_ready", int'(ready), 1);
        check("no_queue_quot", int'(quot), 13);

        // Reset asserted around E4 of a running operation.
        @(negedge clk);
        a = 8'd200;
        b = 4'd3;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("midreset_ready", int'(ready), 0);
        check("midreset_quot", int'(quot), 0);
        check("midreset_rem", int'(rem), 0);
        check("midreset_div0", int'(div0), 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (QW + 3) @(posedge clk);
        #1;
        check("post_reset_no_result", int'(ready), 0);
        prev_q = '0;
        do_op("after_reset", 8'd143, 4'd11, 8'd13, 4'd0, 1'b0, 0);

        // Multiply then divide: a*b / b == a, rem 0.
        for (int x = 0; x < 16; x++) begin
            for (int y = 1; y < 16; y++) begin
                logic [QW-1:0] prod;
                prod = QW'(x * y);
                do_op($sformatf("chain_%0d_%0d", x, y), prod, N'(y), QW'(x), '0, 1'b0, 0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
